// File: rtl/hud_text_sequencer.sv
// HUD SCORE/LEVEL text buffer builder: serial double-dabble conversion, then one atomic commit.
// Optional macro VBLANK_COMMIT_EN holds the commit until the next frame_start pulse.
module hud_text_sequencer #(
    parameter int COLS    = 16,
    parameter int SCORE_W = 20,
    parameter int LEVEL_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score,
    input  logic [LEVEL_W-1:0]    level,
    input  logic                  update_req,
    input  logic                  frame_start,
    output logic [8*COLS*2-1:0]   text,
    output logic                  busy,
    output logic                  done
);

    localparam int TW    = 8 * COLS * 2;
    localparam int MAX_W = (SCORE_W > LEVEL_W) ? SCORE_W : LEVEL_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CONV_S  = 3'd1;
    localparam logic [2:0] CONV_L  = 3'd2;
`ifdef VBLANK_COMMIT_EN
    localparam logic [2:0] WAIT_VB = 3'd3;
`endif
    localparam logic [2:0] COMMIT  = 3'd4;

    localparam logic [39:0] SCORE_LBL = "SCORE";
    localparam logic [39:0] LEVEL_LBL = "LEVEL";

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [SCORE_W-1:0] score_sh;
    logic [LEVEL_W-1:0] level_sh;
    logic [23:0]        bcd_s;
    logic [11:0]        bcd_l;
    logic               pending;

`ifndef VBLANK_COMMIT_EN
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    // Oversized inputs saturate to the largest value the decimal field can show.
    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] v);
        return (64'(v) > 64'd999999) ? SCORE_W'(64'd999999) : v;
    endfunction

    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] v);
        return (64'(v) > 64'd999) ? LEVEL_W'(64'd999) : v;
    endfunction

    // One double-dabble step: add-3 on every nibble >= 5, then shift in the next bit.
    function automatic logic [23:0] dd_step6(input logic [23:0] b, input logic in_bit);
        logic [23:0] c;
        c = b;
        for (int k = 0; k < 6; k++)
            if (b[4*k +: 4] >= 4'd5) c[4*k +: 4] = b[4*k +: 4] + 4'd3;
        return {c[22:0], in_bit};
    endfunction

    function automatic logic [11:0] dd_step3(input logic [11:0] b, input logic in_bit);
        logic [11:0] c;
        c = b;
        for (int k = 0; k < 3; k++)
            if (b[4*k +: 4] >= 4'd5) c[4*k +: 4] = b[4*k +: 4] + 4'd3;
        return {c[10:0], in_bit};
    endfunction

    function automatic logic [TW-1:0] build_text(input logic [23:0] s, input logic [11:0] l);
        logic [TW-1:0] t;
        t = {(2*COLS){8'h20}};
        for (int c = 0; c < 5; c++) begin
            t[8*c +: 8]          = SCORE_LBL[8*(4-c) +: 8];
            t[8*(COLS+c) +: 8]   = LEVEL_LBL[8*(4-c) +: 8];
        end
        for (int d = 0; d < 6; d++)
            t[8*(COLS-6+d) +: 8] = {4'h3, s[4*(5-d) +: 4]};
        for (int d = 0; d < 3; d++)
            t[8*(2*COLS-3+d) +: 8] = {4'h3, l[4*(2-d) +: 4]};
        return t;
    endfunction

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            score_sh <= '0;
            level_sh <= '0;
            bcd_s    <= '0;
            bcd_l    <= '0;
            pending  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            text     <= build_text('0, '0);
        end else begin
            done <= 1'b0;
            if (update_req && state != IDLE) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (update_req || pending) begin
                        score_sh <= clamp_score(score);
                        level_sh <= clamp_level(level);
                        bcd_s    <= '0;
                        bcd_l    <= '0;
                        cnt      <= '0;
                        pending  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CONV_S;
                    end
                end
                CONV_S: begin
                    bcd_s    <= dd_step6(bcd_s, score_sh[SCORE_W-1]);
                    score_sh <= score_sh << 1;
                    if (cnt == CNT_W'(SCORE_W - 1)) begin
                        cnt   <= '0;
                        state <= CONV_L;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CONV_L: begin
                    bcd_l    <= dd_step3(bcd_l, level_sh[LEVEL_W-1]);
                    level_sh <= level_sh << 1;
                    if (cnt == CNT_W'(LEVEL_W - 1)) begin
                        cnt <= '0;
`ifdef VBLANK_COMMIT_EN
                        state <= WAIT_VB;
`else
                        state <= COMMIT;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef VBLANK_COMMIT_EN
                WAIT_VB: begin
                    if (frame_start) state <= COMMIT;
                end
`endif
                COMMIT: begin
                    // Every digit lands in the same edge so the renderer never sees a mixed frame.
                    text  <= build_text(bcd_s, bcd_l);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hud_text_sequencer.sv
// Self-checking bench for hud_text_sequencer: arithmetic reference model plus directed literal checks.
// Build with +define+VBLANK_COMMIT_EN to exercise the vblank-gated commit.
module tb_hud_text_sequencer;

    localparam int COLS    = 16;
    localparam int SCORE_W = 20;
    localparam int LEVEL_W = 8;
    localparam int TW      = 8 * COLS * 2;
`ifdef VBLANK_COMMIT_EN
    localparam int LAT_STD = 32;
`else
    localparam int LAT_STD = 29;
`endif

    logic               clk;
    logic               reset;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;
    logic               update_req;
    logic               frame_start;
    logic [TW-1:0]      text;
    logic               busy;
    logic               done;

    hud_text_sequencer #(.COLS(COLS), .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W)) dut (
        .clk(clk), .reset(reset), .score(score), .level(level),
        .update_req(update_req), .frame_start(frame_start),
        .text(text), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int req_cyc = 0;

    int          done_count = 0;
    int          done_cyc [64];
    logic [47:0] done_dig [64];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] row_str(input int row);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) r = {r[119:0], text[8*(row*COLS+c) +: 8]};
        return r;
    endfunction

    function automatic logic [47:0] score_digits();
        logic [47:0] r;
        r = '0;
        for (int c = 0; c < 6; c++) r = {r[39:0], text[8*(COLS-6+c) +: 8]};
        return r;
    endfunction

    function automatic logic [23:0] level_digits();
        logic [23:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) r = {r[15:0], text[8*(2*COLS-3+c) +: 8]};
        return r;
    endfunction

    // Reference text straight from decimal arithmetic on the clamped values.
    function automatic logic [TW-1:0] fmt(input int s, input int l);
        logic [TW-1:0] t;
        string lbl;
        int row, col, v;
        byte ch;
        t = '0;
        for (int i = 0; i < 2*COLS; i++) begin
            row = i / COLS;
            col = i % COLS;
            ch  = 8'h20;
            lbl = (row == 0) ? "SCORE" : "LEVEL";
            v   = (row == 0) ? s : l;
            if (col < 5) ch = lbl[col];
            else if ((row == 0 && col >= COLS-6) || (row == 1 && col >= COLS-3)) begin
                repeat (COLS-1-col) v = v / 10;
                ch = byte'(8'h30 + v % 10);
            end
            t[8*i +: 8] = ch;
        end
        return t;
    endfunction

    logic [TW-1:0] m_text;
    bit m_busy, m_done, m_pending, m_active, m_valid;
    int m_elapsed, m_s, m_l;
`ifdef VBLANK_COMMIT_EN
    bit m_waiting, m_commit_next;
`endif

    // Compare process: at each falling edge check DUT against the model, then advance the
    // model with the inputs the coming rising edge will sample (inputs only move at posedge+1).
    initial begin
        m_valid = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("text", text, m_text);
                check("busy", busy, m_busy);
                check("done", done, m_done);
                if (done === 1'b1 && done_count < 64) begin
                    done_cyc[done_count] = cyc;
                    done_dig[done_count] = score_digits();
                    done_count++;
                end
            end
            if (reset) begin
                m_text = fmt(0, 0);
                m_busy = 0; m_done = 0; m_pending = 0; m_active = 0; m_valid = 1;
`ifdef VBLANK_COMMIT_EN
                m_waiting = 0; m_commit_next = 0;
`endif
            end else if (m_valid) begin
                m_done = 0;
                if (m_active) begin
                    bit commit_now;
                    commit_now = 0;
                    if (update_req) m_pending = 1;
`ifdef VBLANK_COMMIT_EN
                    if (m_commit_next) commit_now = 1;
                    else if (m_waiting) begin
                        if (frame_start) m_commit_next = 1;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == SCORE_W + LEVEL_W) m_waiting = 1;
                    end
`else
                    m_elapsed++;
                    if (m_elapsed == SCORE_W + LEVEL_W + 1) commit_now = 1;
`endif
                    if (commit_now) begin
                        m_text = fmt(m_s, m_l);
                        m_done = 1; m_busy = 0; m_active = 0;
`ifdef VBLANK_COMMIT_EN
                        m_waiting = 0; m_commit_next = 0;
`endif
                    end
                end else if (update_req || m_pending) begin
                    m_s = int'(score); if (m_s > 999999) m_s = 999999;
                    m_l = int'(level); if (m_l > 999) m_l = 999;
                    m_active = 1; m_busy = 1; m_pending = 0; m_elapsed = 0;
                end
            end
        end
    end

    task automatic do_request(input int s, input int l);
        @(posedge clk); #1;
        score = SCORE_W'(s);
        level = LEVEL_W'(l);
        update_req = 1'b1;
        @(posedge clk); #1;
        req_cyc = cyc;
        update_req = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        bit seen;
        seen = 0; lat = -1; busy_cycles = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                lat = cyc - req_cyc;
            end else begin
                if (busy === 1'b1) busy_cycles++;
                @(posedge clk); #1;
                frame_start = (i == 29);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_done: no done within 200 cycles");
        end
    endtask

    task automatic run_case(input string name, input int s, input int l,
                            input logic [47:0] exp_s, input logic [23:0] exp_l);
        int lat, bc;
        do_request(s, l);
        wait_done(lat, bc);
        check({name, " latency"}, lat, LAT_STD);
        check({name, " busy_cycles"}, bc, LAT_STD);
        check({name, " score_digits"}, score_digits(), exp_s);
        check({name, " level_digits"}, level_digits(), exp_l);
    endtask

    initial begin
        int base, bc;
        reset = 1'b1; update_req = 1'b0; frame_start = 1'b0; score = '0; level = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset row0", row_str(0), "SCORE     000000");
        check("reset row1", row_str(1), "LEVEL        000");
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);

        run_case("basic", 123456, 7, "123456", "007");
        run_case("clamp", 20'hFFFFF, 255, "999999", "255");
        run_case("edge999999", 999999, 0, "999999", "000");
        run_case("first_clamped", 1000000, 100, "999999", "100");

        // Coalesced requests while busy: exactly one extra conversion with fresh samples.
        base = done_count;
        do_request(10, 3);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            score = SCORE_W'(42);
            update_req = (i == 2 || i == 9 || i == 19);
            frame_start = (i % 8 == 7);
        end
        update_req = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        check("pending done_pulses", done_count - base, 2);
        check("pending first", done_dig[base], "000010");
        check("pending second", done_dig[base+1], "000042");
        check("pending idle_after", busy, 1'b0);
`ifndef VBLANK_COMMIT_EN
        check("pending restart_gap", done_cyc[base+1] - done_cyc[base], 30);
`endif

        run_case("index", 9, 0, "000009", "000");
        check("index byte_last", text[8*(COLS-1) +: 8], 8'h39);
        check("index byte0", text[7:0], 8'h53);

        // Reset in the middle of a conversion.
        base = done_count;
        do_request(555, 12);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midreset row0", row_str(0), "SCORE     000000");
        check("midreset row1", row_str(1), "LEVEL        000");
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        repeat (40) @(posedge clk);
        #1 check("midreset no_done", done_count - base, 0);

`ifdef VBLANK_COMMIT_EN
        do_request(5, 0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
        end
        check("vb busy_hold", bc, 40);
        @(posedge clk); #1 frame_start = 1'b1;
        @(negedge clk);
        check("vb text_held", score_digits(), "000000");
        check("vb busy_at_fs", busy, 1'b1);
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        check("vb done_not_yet", done, 1'b0);
        @(negedge clk);
        check("vb done", done, 1'b1);
        check("vb busy_drop", busy, 1'b0);
        check("vb digits", score_digits(), "000005");
`else
        bc = 0;
`endif
        check("bench tail", bc, bc == 0 ? 0 : 40);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
